// File: rtl/gpioemu_mulpop.sv
// Bus-mapped shift-add multiply + popcount; W/L/valid land OP_WIDTH+1 edges after START, 1-cycle reads.
// No backpressure: START/operand writes are dropped while busy. GPIOEMU_MULPOP_HIGH_WORD_EN adds W_HI at +0x28.
module gpioemu_mulpop #(
    parameter int          OP_WIDTH  = 24,
    parameter logic [15:0] BASE_ADDR = 16'h0380,
    parameter int          CNT_WIDTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] saddress,
    input  logic        srd,
    input  logic        swr,
    input  logic [31:0] sdata_in,
    output logic [31:0] sdata_out,
    input  logic [31:0] gpio_in,
    input  logic        gpio_latch,
    output logic [31:0] gpio_out,
    output logic [31:0] gpio_in_s_insp
);

    localparam int PW = 2 * OP_WIDTH;
    localparam int IW = $clog2(OP_WIDTH + 1);

    localparam logic [15:0] ADDR_A1   = BASE_ADDR + 16'h0000;
    localparam logic [15:0] ADDR_A2   = BASE_ADDR + 16'h0008;
    localparam logic [15:0] ADDR_W    = BASE_ADDR + 16'h0010;
    localparam logic [15:0] ADDR_L    = BASE_ADDR + 16'h0018;
    localparam logic [15:0] ADDR_CTRL = BASE_ADDR + 16'h0020;
    localparam logic [15:0] ADDR_WHI  = BASE_ADDR + 16'h0028;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MULT,
        S_COUNT,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [OP_WIDTH-1:0]    a1_q, a1_d;
    logic [OP_WIDTH-1:0]    a2_q, a2_d;
    logic [PW-1:0]          mcand_q, mcand_d;
    logic [OP_WIDTH-1:0]    mplier_q, mplier_d;
    logic [PW-1:0]          product_q, product_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [31:0]            w_q, w_d;
    logic [5:0]             l_q, l_d;
    logic                   ready_q, ready_d;
    logic                   valid_q, valid_d;
    logic [CNT_WIDTH-1:0]   opcount_q, opcount_d;
    logic [31:0]            gpio_in_s_q, gpio_in_s_d;
    logic [31:0]            sdata_out_q, sdata_out_d;
`ifdef GPIOEMU_MULPOP_HIGH_WORD_EN
    logic [31:0]            w_hi_q, w_hi_d;
`endif

    logic [63:0] prod64;
    logic [31:0] rdata;
    logic        wr_a1, wr_a2, start;
    logic        unused_wdata;

    function automatic logic [5:0] popcnt32(input logic [31:0] v);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < 32; i++) begin
            c = c + {5'b0, v[i]};
        end
        return c;
    endfunction

    // Zero-extending to 64 bits keeps the low/high word split valid for every OP_WIDTH.
    assign prod64       = 64'(product_q);
    assign wr_a1        = swr && (saddress == ADDR_A1);
    assign wr_a2        = swr && (saddress == ADDR_A2);
    assign start        = swr && (saddress == ADDR_CTRL) && sdata_in[0];
    assign unused_wdata = ^sdata_in;

    always_comb begin
        rdata = '0;
        if (saddress == ADDR_A1) begin
            rdata = 32'(a1_q);
        end else if (saddress == ADDR_A2) begin
            rdata = 32'(a2_q);
        end else if (saddress == ADDR_W) begin
            rdata = w_q;
        end else if (saddress == ADDR_L) begin
            rdata = {26'b0, l_q};
        end else if (saddress == ADDR_CTRL) begin
            rdata = {30'b0, ready_q, valid_q};
        end else if (saddress == ADDR_WHI) begin
`ifdef GPIOEMU_MULPOP_HIGH_WORD_EN
            rdata = w_hi_q;
`else
            rdata = '0;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        a1_d        = a1_q;
        a2_d        = a2_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        product_d   = product_q;
        idx_d       = idx_q;
        w_d         = w_q;
        l_d         = l_q;
        ready_d     = ready_q;
        valid_d     = valid_q;
        opcount_d   = opcount_q;
`ifdef GPIOEMU_MULPOP_HIGH_WORD_EN
        w_hi_d      = w_hi_q;
`endif
        gpio_in_s_d = gpio_latch ? gpio_in : gpio_in_s_q;
        sdata_out_d = srd ? rdata : sdata_out_q;

        case (state_q)
            S_IDLE: begin
                if (wr_a1) a1_d = sdata_in[OP_WIDTH-1:0];
                if (wr_a2) a2_d = sdata_in[OP_WIDTH-1:0];
                if (start) begin
                    product_d = '0;
                    mcand_d   = PW'(a1_q);
                    mplier_d  = a2_q;
                    idx_d     = '0;
                    ready_d   = 1'b0;
                    state_d   = S_MULT;
                end
            end
            S_MULT: begin
                // mcand holds A1 << i, mplier[0] holds A2[i] on iteration i.
                if (mplier_q[0]) product_d = product_q + mcand_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                if (idx_q == IW'(OP_WIDTH - 1)) begin
                    state_d = S_COUNT;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            S_COUNT: begin
                w_d     = prod64[31:0];
                l_d     = popcnt32(prod64[31:0]);
                valid_d = (prod64[63:32] == 32'b0);
`ifdef GPIOEMU_MULPOP_HIGH_WORD_EN
                w_hi_d  = prod64[63:32];
`endif
                state_d = S_DONE;
            end
            S_DONE: begin
                opcount_d = opcount_q + CNT_WIDTH'(1);
                ready_d   = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            a1_q        <= '0;
            a2_q        <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            product_q   <= '0;
            idx_q       <= '0;
            w_q         <= '0;
            l_q         <= '0;
            ready_q     <= 1'b1;
            valid_q     <= 1'b1;
            opcount_q   <= '0;
            gpio_in_s_q <= '0;
            sdata_out_q <= '0;
`ifdef GPIOEMU_MULPOP_HIGH_WORD_EN
            w_hi_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            a1_q        <= a1_d;
            a2_q        <= a2_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            product_q   <= product_d;
            idx_q       <= idx_d;
            w_q         <= w_d;
            l_q         <= l_d;
            ready_q     <= ready_d;
            valid_q     <= valid_d;
            opcount_q   <= opcount_d;
            gpio_in_s_q <= gpio_in_s_d;
            sdata_out_q <= sdata_out_d;
`ifdef GPIOEMU_MULPOP_HIGH_WORD_EN
            w_hi_q      <= w_hi_d;
`endif
        end
    end

    assign sdata_out      = sdata_out_q;
    assign gpio_out       = 32'(opcount_q);
    assign gpio_in_s_insp = gpio_in_s_q;

endmodule
